// File: rtl/csr_file.sv
// Machine-mode CSR file: trap port, Zicsr instruction port, and 64-bit cycle/instret counters.
// Combinational read of the pre-write value; all updates commit on the rising edge of clk.
module csr_file (
    input  logic        clk,
    input  logic        rst,
    input  logic        csr_write_enable,
    input  logic [11:0] csr_trap_address,
    input  logic [31:0] csr_trap_write_data,
    input  logic        trap_done,
    input  logic        inst_csr_valid,
    input  logic [2:0]  inst_csr_op,
    input  logic [11:0] inst_csr_address,
    input  logic [31:0] inst_csr_wdata,
    input  logic        inst_rs1_zero,
    input  logic        instret,
    output logic [31:0] csr_read_data,
    output logic        csr_illegal
);

    localparam logic [11:0] A_MSTATUS   = 12'h300;
    localparam logic [11:0] A_MISA      = 12'h301;
    localparam logic [11:0] A_MTVEC     = 12'h305;
    localparam logic [11:0] A_MSCRATCH  = 12'h340;
    localparam logic [11:0] A_MEPC      = 12'h341;
    localparam logic [11:0] A_MCAUSE    = 12'h342;
    localparam logic [11:0] A_MCYCLE    = 12'hB00;
    localparam logic [11:0] A_MINSTRET  = 12'hB02;
    localparam logic [11:0] A_MCYCLEH   = 12'hB80;
    localparam logic [11:0] A_MINSTRETH = 12'hB82;
    localparam logic [11:0] A_CYCLE     = 12'hC00;
    localparam logic [11:0] A_INSTRET   = 12'hC02;
    localparam logic [11:0] A_CYCLEH    = 12'hC80;
    localparam logic [11:0] A_INSTRETH  = 12'hC82;
    localparam logic [11:0] A_MVENDORID = 12'hF11;
    localparam logic [11:0] A_MARCHID   = 12'hF12;
    localparam logic [11:0] A_MIMPID    = 12'hF13;
    localparam logic [11:0] A_MHARTID   = 12'hF14;

    logic        mie_q, mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d;
    logic [63:0] minstret_q, minstret_d;

    logic [11:0] rd_addr;
    logic [31:0] inst_old;
    logic [31:0] inst_new;
    logic        inst_is_rw;
    logic        inst_is_sc;
    logic        write_req;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [31:0] wr_data;

    function automatic logic is_mapped(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MISA, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH,
            A_CYCLE, A_INSTRET, A_CYCLEH, A_INSTRETH,
            A_MVENDORID, A_MARCHID, A_MIMPID, A_MHARTID: is_mapped = 1'b1;
            default:                                      is_mapped = 1'b0;
        endcase
    endfunction

    function automatic logic is_writable(input logic [11:0] a);
        case (a)
            A_MSTATUS, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MINSTRET, A_MCYCLEH, A_MINSTRETH: is_writable = 1'b1;
            default:                                      is_writable = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] read_csr(input logic [11:0] a);
        case (a)
            A_MSTATUS:              read_csr = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            A_MISA:                 read_csr = 32'h4000_0100;
            A_MTVEC:                read_csr = mtvec_q;
            A_MSCRATCH:             read_csr = mscratch_q;
            A_MEPC:                 read_csr = mepc_q;
            A_MCAUSE:               read_csr = mcause_q;
            A_MCYCLE,   A_CYCLE:    read_csr = mcycle_q[31:0];
            A_MCYCLEH,  A_CYCLEH:   read_csr = mcycle_q[63:32];
            A_MINSTRET, A_INSTRET:  read_csr = minstret_q[31:0];
            A_MINSTRETH,A_INSTRETH: read_csr = minstret_q[63:32];
            default:                read_csr = 32'h0;
        endcase
    endfunction

    always_comb begin
        rd_addr       = trap_done ? inst_csr_address : csr_trap_address;
        csr_read_data = read_csr(rd_addr);
        inst_old      = read_csr(inst_csr_address);

        inst_is_rw = (inst_csr_op == 3'b001) || (inst_csr_op == 3'b101);
        inst_is_sc = (inst_csr_op == 3'b010) || (inst_csr_op == 3'b011) ||
                     (inst_csr_op == 3'b110) || (inst_csr_op == 3'b111);
        write_req  = inst_csr_valid && (inst_is_rw || (inst_is_sc && !inst_rs1_zero));
        csr_illegal = inst_csr_valid &&
                      (!is_mapped(inst_csr_address) ||
                       ((inst_csr_address[11:10] == 2'b11) && write_req));

        case (inst_csr_op)
            3'b001, 3'b101: inst_new = inst_csr_wdata;
            3'b010, 3'b110: inst_new = inst_old | inst_csr_wdata;
            3'b011, 3'b111: inst_new = inst_old & ~inst_csr_wdata;
            default:        inst_new = inst_old;
        endcase

        // The trap port owns the write path whenever it strobes, even if its target is read-only.
        if (csr_write_enable) begin
            wr_en   = is_writable(csr_trap_address);
            wr_addr = csr_trap_address;
            wr_data = csr_trap_write_data;
        end else begin
            wr_en   = write_req && !csr_illegal && is_writable(inst_csr_address);
            wr_addr = inst_csr_address;
            wr_data = inst_new;
        end
    end

    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, instret};
        // A write to either counter half replaces that counter's increment for this cycle.
        if (wr_en) begin
            case (wr_addr)
                A_MSTATUS: begin
                    mie_d  = wr_data[3];
                    mpie_d = wr_data[7];
                end
                A_MTVEC:     mtvec_d    = {wr_data[31:2], 2'b00};
                A_MSCRATCH:  mscratch_d = wr_data;
                A_MEPC:      mepc_d     = {wr_data[31:2], 2'b00};
                A_MCAUSE:    mcause_d   = wr_data;
                A_MCYCLE:    mcycle_d   = {mcycle_q[63:32], wr_data};
                A_MCYCLEH:   mcycle_d   = {wr_data, mcycle_q[31:0]};
                A_MINSTRET:  minstret_d = {minstret_q[63:32], wr_data};
                A_MINSTRETH: minstret_d = {wr_data, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= 32'h0;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Randomized and directed bench for csr_file against an architectural model of the CSR map.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_write_enable;
    logic [11:0] csr_trap_address;
    logic [31:0] csr_trap_write_data;
    logic        trap_done;
    logic        inst_csr_valid;
    logic [2:0]  inst_csr_op;
    logic [11:0] inst_csr_address;
    logic [31:0] inst_csr_wdata;
    logic        inst_rs1_zero;
    logic        instret;
    logic [31:0] csr_read_data;
    logic        csr_illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    csr_file dut (
        .clk                 (clk),
        .rst                 (rst),
        .csr_write_enable    (csr_write_enable),
        .csr_trap_address    (csr_trap_address),
        .csr_trap_write_data (csr_trap_write_data),
        .trap_done           (trap_done),
        .inst_csr_valid      (inst_csr_valid),
        .inst_csr_op         (inst_csr_op),
        .inst_csr_address    (inst_csr_address),
        .inst_csr_wdata      (inst_csr_wdata),
        .inst_rs1_zero       (inst_rs1_zero),
        .instret             (instret),
        .csr_read_data       (csr_read_data),
        .csr_illegal         (csr_illegal)
    );

    // Architectural model state
    logic [31:0] m_mstatus, m_mtvec, m_mscratch, m_mepc, m_mcause;
    logic [63:0] m_cycle, m_instret;

    logic [11:0] addr_tbl [20] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                                   12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                   12'hC02, 12'hC82, 12'hF11, 12'hF14, 12'h7C0, 12'h000,
                                   12'h344, 12'hC01};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_mapped(input logic [11:0] a);
        return a inside {12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                         12'hC02, 12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14};
    endfunction

    function automatic bit m_writable(input logic [11:0] a);
        return a inside {12'h300, 12'h305, 12'h340, 12'h341, 12'h342,
                         12'hB00, 12'hB80, 12'hB02, 12'hB82};
    endfunction

    function automatic logic [31:0] m_read(input logic [11:0] a);
        case (a)
            12'h300: return m_mstatus;
            12'h301: return 32'h4000_0100;
            12'h305: return m_mtvec;
            12'h340: return m_mscratch;
            12'h341: return m_mepc;
            12'h342: return m_mcause;
            12'hB00, 12'hC00: return m_cycle[31:0];
            12'hB80, 12'hC80: return m_cycle[63:32];
            12'hB02, 12'hC02: return m_instret[31:0];
            12'hB82, 12'hC82: return m_instret[63:32];
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit m_write_req();
        if (!inst_csr_valid) return 1'b0;
        if (inst_csr_op == 3'd1 || inst_csr_op == 3'd5) return 1'b1;
        if (inst_csr_op inside {3'd2, 3'd3, 3'd6, 3'd7}) return !inst_rs1_zero;
        return 1'b0;
    endfunction

    function automatic bit m_illegal();
        return inst_csr_valid && (!m_mapped(inst_csr_address) ||
               (inst_csr_address[11:10] == 2'b11 && m_write_req()));
    endfunction

    task automatic m_reset();
        m_mstatus = 32'h1800; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
        m_cycle = 0; m_instret = 0;
    endtask

    task automatic m_step();
        bit          wr;
        logic [11:0] wa;
        logic [31:0] wd, old;
        logic [63:0] nc, ni;
        if (rst) begin
            m_reset();
            return;
        end
        wr = 0; wa = 0; wd = 0;
        if (csr_write_enable) begin
            wr = m_writable(csr_trap_address);
            wa = csr_trap_address;
            wd = csr_trap_write_data;
        end else if (m_write_req() && !m_illegal() && m_writable(inst_csr_address)) begin
            wr  = 1;
            wa  = inst_csr_address;
            old = m_read(wa);
            if (inst_csr_op[1:0] == 2'b01)      wd = inst_csr_wdata;
            else if (inst_csr_op[1:0] == 2'b10) wd = old | inst_csr_wdata;
            else                                wd = old & ~inst_csr_wdata;
        end
        nc = m_cycle + 1;
        ni = m_instret + (instret ? 1 : 0);
        if (wr) begin
            case (wa)
                12'h300: m_mstatus  = 32'h1800 | (wd & 32'h88);
                12'h305: m_mtvec    = wd & ~32'h3;
                12'h340: m_mscratch = wd;
                12'h341: m_mepc     = wd & ~32'h3;
                12'h342: m_mcause   = wd;
                12'hB00: nc = {m_cycle[63:32], wd};
                12'hB80: nc = {wd, m_cycle[31:0]};
                12'hB02: ni = {m_instret[63:32], wd};
                12'hB82: ni = {wd, m_instret[31:0]};
                default: ;
            endcase
        end
        m_cycle   = nc;
        m_instret = ni;
    endtask

    // One clock: compare combinational outputs against the model, then advance both.
    task automatic cyc();
        #1;
        check("rdata", csr_read_data, m_read(trap_done ? inst_csr_address : csr_trap_address));
        check("illegal", {31'b0, csr_illegal}, {31'b0, m_illegal()});
        @(posedge clk);
        m_step();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; csr_write_enable = 0; csr_trap_address = 0; csr_trap_write_data = 0;
        trap_done = 0; inst_csr_valid = 0; inst_csr_op = 0; inst_csr_address = 0;
        inst_csr_wdata = 0; inst_rs1_zero = 0; instret = 0;
    endtask

    task automatic trap_wr(input logic [11:0] a, input logic [31:0] d);
        idle(); csr_write_enable = 1; csr_trap_address = a; csr_trap_write_data = d; cyc();
    endtask

    task automatic trap_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        idle(); csr_trap_address = a; #1; check(tag, csr_read_data, exp); cyc();
    endtask

    task automatic inst(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d,
                        input logic rz);
        idle(); trap_done = 1; inst_csr_valid = 1; inst_csr_op = op;
        inst_csr_address = a; inst_csr_wdata = d; inst_rs1_zero = rz;
    endtask

    initial begin
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 0;

        trap_rd("mcycle_after_reset", 12'hB00, 32'h0);
        repeat (4) cyc();
        trap_rd("mcycle_5", 12'hB00, 32'd5);
        trap_rd("mstatus_reset", 12'h300, 32'h0000_1800);
        trap_rd("misa_reset", 12'h301, 32'h4000_0100);
        trap_rd("mtvec_reset", 12'h305, 32'h0);

        trap_wr(12'h341, 32'h0000_1003);
        trap_wr(12'h342, 32'd11);
        trap_rd("mepc_masked", 12'h341, 32'h0000_1000);
        trap_rd("mcause", 12'h342, 32'd11);
        trap_wr(12'h305, 32'h0000_0203);
        trap_rd("mtvec_masked", 12'h305, 32'h0000_0200);
        trap_wr(12'h301, 32'hDEAD_BEEF);
        trap_rd("misa_ro", 12'h301, 32'h4000_0100);

        inst(3'b010, 12'h300, 32'h8, 0); #1; check("rs_illegal", {31'b0, csr_illegal}, 0); cyc();
        inst(3'b011, 12'h300, 32'h8, 0); #1; check("mstatus_set", csr_read_data, 32'h1808); cyc();
        inst(3'b010, 12'h300, 32'h8, 1); #1; check("mstatus_clr", csr_read_data, 32'h1800); cyc();
        trap_rd("mstatus_rs_zero", 12'h300, 32'h1800);

        inst(3'b001, 12'hC00, 32'h1234, 0); #1; check("rw_ro_illegal", {31'b0, csr_illegal}, 1); cyc();
        inst(3'b001, 12'h7C0, 32'h1234, 0); #1; check("unmapped_illegal", {31'b0, csr_illegal}, 1); cyc();
        inst(3'b010, 12'hC00, 32'h0, 1); #1;
        check("rs0_ro_legal", {31'b0, csr_illegal}, 0);
        check("cycle_alias", csr_read_data, m_cycle[31:0]);
        cyc();

        trap_wr(12'hB80, 32'hFFFF_FFFF);
        trap_wr(12'hB00, 32'hFFFF_FFFF);
        trap_rd("mcycle_full", 12'hB00, 32'hFFFF_FFFF);
        trap_rd("mcycleh_wrap", 12'hB80, 32'h0);
        trap_rd("mcycle_wrap", 12'hB00, 32'h1);

        trap_wr(12'hB82, 32'h0);
        trap_wr(12'hB02, 32'h0);
        repeat (3) begin idle(); instret = 1; cyc(); end
        trap_rd("minstret_3", 12'hB02, 32'd3);

        inst(3'b001, 12'h340, 32'h5A, 0);
        csr_write_enable = 1; csr_trap_address = 12'h340; csr_trap_write_data = 32'hA5;
        cyc();
        trap_rd("trap_priority", 12'h340, 32'hA5);

        for (int i = 0; i < 3000; i++) begin
            rst                 = ($urandom_range(199) == 0);
            csr_write_enable    = ($urandom_range(3) == 0);
            csr_trap_address    = addr_tbl[$urandom_range(19)];
            csr_trap_write_data = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
            trap_done           = $urandom_range(1);
            inst_csr_valid      = $urandom_range(1);
            inst_csr_op         = 3'($urandom_range(7));
            inst_csr_address    = addr_tbl[$urandom_range(19)];
            inst_rs1_zero       = ($urandom_range(3) == 0);
            inst_csr_wdata      = inst_rs1_zero ? 32'h0 : $urandom;
            instret             = $urandom_range(1);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
